scan_seq_138: RTL and testbench

Registered scan sequencer that drives the select and enable inputs of the 3-to-8 active-low decoder stage. On a start request it walks channels 0..7 in ascending order, skips masked channels, holds each channel for a programmable dwell time, and inserts blanking cycles between channels with the decoder disabled (break-before-make). It runs one frame or repeats continuously. It also reports busy and frame-complete status to the controlling logic.

---
 rtl/scan_seq_pkg.sv | 16 +
 rtl/scan_next_ch.sv | 27 ++
 rtl/scan_seq_138.sv | 191 +++++++++++++++++++
 tb/tb_scan_seq_138.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
package scan_seq_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_e;

  // Decoder enable patterns packed as {g1, g2a_n, g2b_n}.
  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel finder: next unmasked channel above cur_i, and lowest unmasked channel.
module scan_next_ch
  import scan_seq_pkg::*;
(
  input  logic [7:0] mask_i,
  input  logic [2:0] cur_i,
  output logic [2:0] next_o,
  output logic       found_o,
  output logic [2:0] low_o,
  output logic       any_o
);

  // Walk from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    next_o  = 3'd0;
    found_o = 1'b0;
    low_o   = 3'd0;
    any_o   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      next_o  = (!mask_i[i] && (3'(i) > cur_i)) ? 3'(i) : next_o;
      found_o = (!mask_i[i] && (3'(i) > cur_i)) ? 1'b1 : found_o;
      low_o   = (!mask_i[i]) ? 3'(i) : low_o;
      any_o   = (!mask_i[i]) ? 1'b1 : any_o;
    end
  end

endmodule

// File: rtl/scan_seq_138.sv
// Scan sequencer driving a 3-to-8 active-low decoder with break-before-make blanking.
// Optional frame counter output enabled by defining SCAN_FRAME_CNT_EN.
module scan_seq_138
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               continuous_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [7:0]         mask_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic [2:0]         chan_o,
  output logic               busy_o,
  output logic               frame_done_o
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt_o
`endif
);

  localparam int BW    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int CNT_W = (DWELL_W > BW) ? DWELL_W : BW;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam state_e FIRST_ST = (BLANK_CYCLES == 0) ? DWELL : BLANK;

  state_e             state_q, state_d;
  logic [2:0]         chan_q, chan_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2:0]         nxt_ch_s, low_ch_s, nc_low_s, nc_nxt_s;
  logic               nxt_found_s, low_any_s, nc_any_s, nc_found_s;
  logic [DWELL_W-1:0] dwell_eff_s;
  logic               dwell_last_s;
  logic               nc_unused_s;

  // Next channel within the latched mask; lowest channel of the live mask for start and wrap.
  scan_next_ch u_next (
    .mask_i (mask_q),
    .cur_i  (chan_q),
    .next_o (nxt_ch_s),
    .found_o(nxt_found_s),
    .low_o  (nc_low_s),
    .any_o  (nc_any_s)
  );

  scan_next_ch u_low (
    .mask_i (mask_i),
    .cur_i  (3'd0),
    .next_o (nc_nxt_s),
    .found_o(nc_found_s),
    .low_o  (low_ch_s),
    .any_o  (low_any_s)
  );

  assign nc_unused_s  = ^{nc_low_s, nc_any_s, nc_nxt_s, nc_found_s};
  assign dwell_eff_s  = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
  assign dwell_last_s = (cnt_q == (CNT_W'(dwell_q) - CNT_W'(1)));

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dwell_d = dwell_eff_s;
            mask_d  = mask_i;
            cnt_d   = '0;
            if (low_any_s) begin
              chan_d  = low_ch_s;
              state_d = FIRST_ST;
            end else begin
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = DWELL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DWELL: begin
          if (dwell_last_s) begin
            cnt_d = '0;
            if (nxt_found_s) begin
              chan_d  = nxt_ch_s;
              state_d = FIRST_ST;
            end else begin
              done_d = 1'b1;
              if (continuous_i && low_any_s) begin
                mask_d  = mask_i;
                chan_d  = low_ch_s;
                state_d = FIRST_ST;
              end else begin
                mask_d  = continuous_i ? mask_i : mask_q;
                state_d = IDLE;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    en_d   = (state_d == DWELL) ? EN_ON : EN_OFF;
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      chan_q  <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= 8'd0;
      en_q    <= EN_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter steps on the same edge that raises frame_done_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= 16'd0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  assign chan_o       = chan_q;
  assign select_a_o   = chan_q[0];
  assign select_b_o   = chan_q[1];
  assign select_c_o   = chan_q[2];
  assign g1_en_o      = en_q[2];
  assign g2a_en_n_o   = en_q[1];
  assign g2b_en_n_o   = en_q[0];
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_scan_seq_138.sv
// Directed self-checking bench for scan_seq_138 (DWELL_W=8, BLANK_CYCLES=1).
module tb_scan_seq_138;

  logic       clk_i, rst_i, start_i, stop_i, continuous_i;
  logic [7:0] dwell_i, mask_i;
  logic       select_a_o, select_b_o, select_c_o;
  logic       g1_en_o, g2a_en_n_o, g2b_en_n_o;
  logic [2:0] chan_o;
  logic       busy_o, frame_done_o;
`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_chan = 3'd0;

  scan_seq_138 #(.DWELL_W(8), .BLANK_CYCLES(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .continuous_i(continuous_i),
    .dwell_i     (dwell_i),
    .mask_i      (mask_i),
    .select_a_o  (select_a_o),
    .select_b_o  (select_b_o),
    .select_c_o  (select_c_o),
    .g1_en_o     (g1_en_o),
    .g2a_en_n_o  (g2a_en_n_o),
    .g2b_en_n_o  (g2b_en_n_o),
    .chan_o      (chan_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
`ifdef SCAN_FRAME_CNT_EN
    ,
    .frame_cnt_o (frame_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] ch;
    logic       en;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[18];

  // Packed view: {chan, c, b, a, g1, g2a_n, g2b_n, busy, done}
  function automatic logic [10:0] mk(logic [2:0] ch, logic en, logic busy, logic done);
    return {ch, ch[2], ch[1], ch[0], en, ~en, ~en, busy, done};
  endfunction

  function automatic logic [10:0] observed();
    return {chan_o, select_c_o, select_b_o, select_a_o, g1_en_o, g2a_en_n_o, g2b_en_n_o,
            busy_o, frame_done_o};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b ({chan,c,b,a,g1,g2a_n,g2b_n,busy,done})",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (chan_o !== prev_chan) begin
      checks++;
      if (g1_en_o !== 1'b0) begin
        errors++;
        $display("FAIL sel_while_enabled: chan %0d -> %0d with g1=%b required g1=0",
                 prev_chan, chan_o, g1_en_o);
      end
    end
    prev_chan = chan_o;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd6, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd6, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd6, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 3'd6, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'h7F, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'h7F, 3'd7, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'h7F, 3'd7, 1'b0, 1'b0, 1'b0};

    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; continuous_i = 1'b0;
    dwell_i = 8'd0; mask_i = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_values", observed(), mk(3'd0, 1'b0, 1'b0, 1'b0));
`ifdef SCAN_FRAME_CNT_EN
    checks++;
    if (frame_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_reset: got %0d required 0", frame_cnt_o);
    end
`endif
    rst_i = 1'b0;
    tick();
    check("idle_after_reset", observed(), mk(3'd0, 1'b0, 1'b0, 1'b0));

    // Mask A5 single frame, then continuous on channel 7 only.
    for (int i = 0; i < 18; i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; continuous_i = vecs[i].cont;
      dwell_i = vecs[i].dwell; mask_i = vecs[i].mask;
      tick();
      check($sformatf("vec%0d", i), observed(),
            mk(vecs[i].ch, vecs[i].en, vecs[i].busy, vecs[i].done));
    end
    start_i = 1'b0; continuous_i = 1'b0;
`ifdef SCAN_FRAME_CNT_EN
    checks++;
    if (frame_cnt_o !== 16'd4) begin
      errors++;
      $display("FAIL frame_cnt_count: got %0d required 4", frame_cnt_o);
    end
`endif

    // Full frame, dwell 2: 8 x (1 blank + 2 dwell) = 24 cycles.
    mask_i = 8'h00; dwell_i = 8'd2; start_i = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      tick();
      start_i = 1'b0;
      if (k < 24)
        check($sformatf("full_k%0d", k), observed(), mk(3'(k / 3), (k % 3) != 0, 1'b1, 1'b0));
      else
        check($sformatf("full_k%0d", k), observed(), mk(3'd7, 1'b0, 1'b0, k == 24));
    end

    // Stop in the second dwell cycle of channel 3 with start also high.
    dwell_i = 8'd3; start_i = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      start_i = 1'b0;
    end
    check("stop_pre", observed(), mk(3'd3, 1'b1, 1'b1, 1'b0));
    stop_i = 1'b1; start_i = 1'b1;
    tick();
    check("stop_idle", observed(), mk(3'd3, 1'b0, 1'b0, 1'b0));
    tick();
    check("stop_beats_start", observed(), mk(3'd3, 1'b0, 1'b0, 1'b0));
    stop_i = 1'b0; start_i = 1'b0;
    tick();
    check("stop_no_done", observed(), mk(3'd3, 1'b0, 1'b0, 1'b0));

    // All channels masked: immediate done pulse, never busy.
    mask_i = 8'hFF; start_i = 1'b1;
    tick();
    check("allmask_done", observed(), mk(3'd3, 1'b0, 1'b0, 1'b1));
    start_i = 1'b0;
    tick();
    check("allmask_after", observed(), mk(3'd3, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset in the first dwell cycle of channel 5.
    mask_i = 8'h00; dwell_i = 8'd2; start_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      start_i = 1'b0;
    end
    check("pre_reset_ch5", observed(), mk(3'd5, 1'b1, 1'b1, 1'b0));
    #2 rst_i = 1'b1;
    #1;
    check("async_reset", observed(), mk(3'd0, 1'b0, 1'b0, 1'b0));
    #1 rst_i = 1'b0;
    tick();
    check("idle_after_async_reset", observed(), mk(3'd0, 1'b0, 1'b0, 1'b0));
    tick();
    check("idle_hold", observed(), mk(3'd0, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
